// File: rtl/dlx_pkg.sv
// DLX write-back shared types and result formatting helpers.
// Holds the FIFO entry layout plus load alignment and destination decode.
package dlx_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2,
        WB_LINK = 2'd3
    } wb_kind_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } ld_size_t;

    typedef struct packed {
        wb_kind_t    kind;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        ld_size_t    size;
        logic        sgn;
        logic [1:0]  addr_lo;
        logic [31:0] pc;
    } wb_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Big-endian lane select; misaligned accesses drop the low address bits.
    function automatic logic [31:0] ld_align(
        input logic [31:0] mem,
        input ld_size_t    size,
        input logic        sgn,
        input logic [1:0]  addr_lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (addr_lo)
            2'd0:    b = mem[31:24];
            2'd1:    b = mem[23:16];
            2'd2:    b = mem[15:8];
            default: b = mem[7:0];
        endcase
        h = addr_lo[1] ? mem[15:0] : mem[31:16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = mem;
        endcase
        return r;
    endfunction

    function automatic logic ld_misalign(
        input ld_size_t   size,
        input logic [1:0] addr_lo
    );
        logic m;
        case (size)
            SZ_HALF: m = addr_lo[0];
            SZ_WORD: m = (addr_lo != 2'd0);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] wb_data(input wb_entry_t e);
        logic [31:0] d;
        case (e.kind)
            WB_ALU:  d = e.alu;
            WB_LOAD: d = ld_align(e.mem, e.size, e.sgn, e.addr_lo);
            WB_LINK: d = e.pc + 32'd4;
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    function automatic logic [4:0] wb_dest(
        input wb_entry_t  e,
        input logic [4:0] link_reg
    );
        return (e.kind == WB_LINK) ? link_reg : e.rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back entries.
// Supports push and pop in the same cycle, including when full.
module wb_fifo
    import dlx_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_unit.sv
// DLX write-back stage: result FIFO, formatting, register write and scoreboard.
// Optional WB_FWD_EN exposes the FIFO head's formatted result for bypass.
module wb_unit
    import dlx_pkg::*;
#(
    parameter int         DEPTH    = 2,
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_mem,
    input  logic [1:0]  in_size,
    input  logic        in_signed,
    input  logic [1:0]  in_addr_lo,
    input  logic [31:0] in_pc,
    input  logic        wb_hold,
    output logic        WB,
    output logic [4:0]  Rd,
    output logic [31:0] reg_s,
    output logic [31:0] pending,
    output logic        misalign
`ifdef WB_FWD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data
`endif
);

    wb_entry_t   in_e;
    wb_entry_t   head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [4:0]  head_dest;
    logic [31:0] head_data;
    logic        head_wr;
    logic [31:0] pend_nxt;

    assign in_e = '{
        kind:    wb_kind_t'(in_kind),
        rd:      in_rd,
        alu:     in_alu,
        mem:     in_mem,
        size:    ld_size_t'(in_size),
        sgn:     in_signed,
        addr_lo: in_addr_lo,
        pc:      in_pc
    };

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !wb_hold;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_e),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign head_dest = wb_dest(head, LINK_REG);
    assign head_data = wb_data(head);
    assign head_wr   = (head.kind != WB_NONE) && (head_dest != REG_ZERO);

`ifdef WB_FWD_EN
    assign fwd_valid = !empty && head_wr;
    assign fwd_rd    = head_dest;
    assign fwd_data  = head_data;
`endif

    // Register write port; Rd/reg_s hold their values when nothing is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            WB       <= 1'b0;
            Rd       <= REG_ZERO;
            reg_s    <= 32'd0;
            misalign <= 1'b0;
        end else begin
            misalign <= pop && (head.kind == WB_LOAD)
                        && ld_misalign(head.size, head.addr_lo);
            if (pop && head_wr) begin
                WB    <= 1'b1;
                Rd    <= head_dest;
                reg_s <= head_data;
            end else begin
                WB    <= 1'b0;
            end
        end
    end

    // Scoreboard next state: a new claim overrides a retiring write.
    always_comb begin
        pend_nxt = pending;
        if (pop && head_wr) pend_nxt[head_dest] = 1'b0;
        if (iss_valid)      pend_nxt[iss_rd]    = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) pending <= 32'd0;
        else     pending <= pend_nxt;
    end

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard testbench for wb_unit: directed pushes queue expected writes,
// a negedge monitor checks every write strobe against the queue.
module tb_wb_unit;
    import dlx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [31:0] in_alu;
    logic [31:0] in_mem;
    logic [1:0]  in_size;
    logic        in_signed;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_pc;
    logic        wb_hold;
    logic        WB;
    logic [4:0]  Rd;
    logic [31:0] reg_s;
    logic [31:0] pending;
    logic        misalign;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    wb_unit dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rd      (in_rd),
        .in_alu     (in_alu),
        .in_mem     (in_mem),
        .in_size    (in_size),
        .in_signed  (in_signed),
        .in_addr_lo (in_addr_lo),
        .in_pc      (in_pc),
        .wb_hold    (wb_hold),
        .WB         (WB),
        .Rd         (Rd),
        .reg_s      (reg_s),
        .pending    (pending),
        .misalign   (misalign)
`ifdef WB_FWD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after acceptance.
    task automatic push(input logic [1:0] k, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [1:0] sz, input logic sg,
                        input logic [1:0] al, input logic [31:0] pc,
                        input logic wr, input logic [4:0] erd,
                        input logic [31:0] edata, input logic emis);
        int n;
        n = 0;
        in_valid = 1'b1; in_kind = k; in_rd = rd; in_alu = alu;
        in_mem = mem; in_size = sz; in_signed = sg; in_addr_lo = al;
        in_pc = pc;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", {31'd0, in_ready}, 32'd1);
        else if (wr) q.push_back('{erd, edata, emis});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (WB) begin
                if (q.size() == 0) begin
                    chk("unexpected_wb", {31'd0, WB}, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("wb_rd", {27'd0, Rd}, {27'd0, mon_e.rd});
                    chk("wb_data", reg_s, mon_e.data);
                    chk("wb_mis", {31'd0, misalign}, {31'd0, mon_e.mis});
                end
            end else if (misalign) begin
                chk("stray_misalign", {31'd0, misalign}, 32'd0);
            end
        end
    end

    initial begin
        int nw;
        int n;
        rst = 1'b1; iss_valid = 1'b0; iss_rd = 5'd0; in_valid = 1'b0;
        in_kind = 2'd0; in_rd = 5'd0; in_alu = '0; in_mem = '0;
        in_size = 2'd0; in_signed = 1'b0; in_addr_lo = 2'd0;
        in_pc = '0; wb_hold = 1'b1;
        tick(3);
        rst = 1'b0; wb_hold = 1'b0;
        @(negedge clk);
        chk("rst_wb", {31'd0, WB}, 32'd0);
        chk("rst_rd", {27'd0, Rd}, 32'd0);
        chk("rst_data", reg_s, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // 1: ALU latency
        tick(1);
        push(WB_ALU, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0,
             1, 5'd5, 32'hDEADBEEF, 0);
        @(negedge clk);
        chk("t1_cyc1_wb", {31'd0, WB}, 32'd0);
        @(negedge clk);
        chk("t1_cyc2_wb", {31'd0, WB}, 32'd1);
        @(negedge clk);
        chk("t1_cyc3_wb", {31'd0, WB}, 32'd0);
        tick(1);

        // 2: byte loads
        push(WB_LOAD, 5'd6, 0, 32'h12F45678, SZ_BYTE, 1, 2'd1, 0,
             1, 5'd6, 32'hFFFFFFF4, 0);
        push(WB_LOAD, 5'd8, 0, 32'h12F45678, SZ_BYTE, 0, 2'd1, 0,
             1, 5'd8, 32'h000000F4, 0);
        push(WB_LOAD, 5'd10, 0, 32'h12F45678, SZ_BYTE, 0, 2'd3, 0,
             1, 5'd10, 32'h00000078, 0);
        push(WB_LOAD, 5'd11, 0, 32'h8000_1234, SZ_HALF, 1, 2'd0, 0,
             1, 5'd11, 32'hFFFF8000, 0);
        tick(3);

        // 3: misaligned half and word
        push(WB_LOAD, 5'd9, 0, 32'h1234ABCD, SZ_HALF, 0, 2'd3, 0,
             1, 5'd9, 32'h0000ABCD, 1);
        push(WB_LOAD, 5'd12, 0, 32'hCAFEF00D, SZ_WORD, 0, 2'd2, 0,
             1, 5'd12, 32'hCAFEF00D, 1);
        tick(3);

        // 4: link wraps and clears r31
        iss_valid = 1'b1; iss_rd = 5'd31;
        tick(1);
        iss_valid = 1'b0;
        chk("link_claim", pending, 32'h80000000);
        push(WB_LINK, 5'd3, 0, 0, 0, 0, 0, 32'hFFFFFFFC,
             1, 5'd31, 32'h00000000, 0);
        tick(3);
        chk("link_clear", pending, 32'd0);

        // NONE and rd=0 never write; outputs hold
        push(WB_NONE, 5'd4, 32'h1111, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(WB_ALU, 5'd0, 32'h2222, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nw = 0;
        repeat (4) begin
            @(negedge clk);
            if (WB) nw++;
        end
        chk("no_write", nw, 32'd0);
        chk("rd_hold", {27'd0, Rd}, 32'd31);
        chk("data_hold", reg_s, 32'd0);
        tick(1);

        // 5: scoreboard
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick(1);
        iss_valid = 1'b0;
        chk("pend_set", pending, 32'h00000080);
        push(WB_ALU, 5'd7, 32'h77, 0, 0, 0, 0, 0, 1, 5'd7, 32'h77, 0);
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick(1);
        iss_valid = 1'b0;
        @(negedge clk);
        chk("pend_set_wins", pending, 32'h00000080);
        tick(1);
        push(WB_ALU, 5'd7, 32'h78, 0, 0, 0, 0, 0, 1, 5'd7, 32'h78, 0);
        tick(3);
        chk("pend_clear", pending, 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick(1);
        iss_valid = 1'b0;
        chk("pend_zero", pending, 32'd0);

        // 6: hold, fill, ordered drain
        wb_hold = 1'b1;
        push(WB_ALU, 5'd1, 32'hA1, 0, 0, 0, 0, 0, 1, 5'd1, 32'hA1, 0);
        push(WB_ALU, 5'd2, 32'hB2, 0, 0, 0, 0, 0, 1, 5'd2, 32'hB2, 0);
        @(negedge clk);
        chk("ready_full", {31'd0, in_ready}, 32'd0);
        chk("hold_no_wb", {31'd0, WB}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_kind = WB_ALU; in_rd = 5'd3; in_alu = 32'hC3;
        q.push_back('{5'd3, 32'hC3, 1'b0});
        wb_hold = 1'b0;
        @(negedge clk);
        chk("c_held", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("drain_a_wb", {31'd0, WB}, 32'd1);
        chk("drain_a_rd", {27'd0, Rd}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_b_wb", {31'd0, WB}, 32'd1);
        chk("drain_b_rd", {27'd0, Rd}, 32'd2);
        @(negedge clk);
        chk("drain_c_wb", {31'd0, WB}, 32'd1);
        chk("drain_c_rd", {27'd0, Rd}, 32'd3);
        tick(2);

        // reset mid-burst discards everything
        wb_hold = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd4;
        push(WB_ALU, 5'd4, 32'hD4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        iss_rd = 5'd5;
        push(WB_ALU, 5'd5, 32'hE5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        iss_valid = 1'b0;
        chk("burst_pend", pending, 32'h00000030);
        rst = 1'b1; wb_hold = 1'b0;
        tick(1);
        rst = 1'b0;
        chk("rst_mid_pend", pending, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        nw = 0;
        repeat (5) begin
            @(negedge clk);
            if (WB) nw++;
        end
        chk("rst_mid_no_wb", nw, 32'd0);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drain", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
